// File: rtl/wbu_queue.sv
// Writeback queue: buffers MEM results in a DEPTH-entry FIFO, retires one per
// cycle under m_ready backpressure, and forwards the youngest matching result.
module wbu_queue #(
    parameter int DATA_WIDTH     = 32,
    parameter int PC_WIDTH       = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int DEPTH          = 4,
    parameter int NUM_FWD        = 2,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                flush,
    input  logic                                s_valid,
    output logic                                s_ready,
    input  logic [PC_WIDTH-1:0]                 s_pc,
    input  logic [31:0]                         s_instr,
    input  logic [PC_WIDTH-1:0]                 s_pc_4,
    input  logic                                s_reg_wen,
    input  logic [1:0]                          s_wb_sel,
    input  logic [REG_ADDR_WIDTH-1:0]           s_waddr,
    input  logic [DATA_WIDTH-1:0]               s_alu_out,
    input  logic [DATA_WIDTH-1:0]               s_mem_out,
    input  logic                                s_branch_taken,
    output logic                                m_valid,
    input  logic                                m_ready,
    output logic                                wb_reg_wen,
    output logic [REG_ADDR_WIDTH-1:0]           wb_reg_waddr,
    output logic [DATA_WIDTH-1:0]               wb_reg_wdata,
    output logic [PC_WIDTH-1:0]                 wb_pc,
    output logic [31:0]                         wb_instr,
    output logic                                wb_branch_taken,
    output logic                                trap,
    input  logic [NUM_FWD*REG_ADDR_WIDTH-1:0]   fwd_raddr,
    output logic [NUM_FWD-1:0]                  fwd_hit,
    output logic [NUM_FWD*DATA_WIDTH-1:0]       fwd_data,
    output logic [$clog2(DEPTH):0]              count,
    output logic [CNT_WIDTH-1:0]                retired
);

    localparam int AW = $clog2(DEPTH);
    localparam int RW = REG_ADDR_WIDTH;
    localparam int DW = DATA_WIDTH;
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    localparam logic [31:0] EBREAK = 32'h00100073;

    logic [AW-1:0]        rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [AW:0]          count_q, count_d;
    logic [CNT_WIDTH-1:0] retired_q, retired_d;
    logic [DEPTH-1:0]     vld_q, vld_d;

    logic [PC_WIDTH-1:0]  pc_q    [DEPTH];
    logic [PC_WIDTH-1:0]  pc_d    [DEPTH];
    logic [31:0]          instr_q [DEPTH];
    logic [31:0]          instr_d [DEPTH];
    logic [DW-1:0]        wdata_q [DEPTH];
    logic [DW-1:0]        wdata_d [DEPTH];
    logic [RW-1:0]        waddr_q [DEPTH];
    logic [RW-1:0]        waddr_d [DEPTH];
    logic [DEPTH-1:0]     wen_q, wen_d, bt_q, bt_d;

    logic          enq, ret;
    logic [DW-1:0] s_wdata;

    assign m_valid = (count_q != '0) && !flush;
    assign s_ready = (count_q < FULL) || (m_ready && m_valid);
    assign ret     = m_valid && m_ready;
    assign enq     = s_valid && s_ready && !flush;
    assign count   = count_q;
    assign retired = retired_q;

    always_comb begin
        s_wdata = s_mem_out;
        case (s_wb_sel)
            2'd0:    s_wdata = s_alu_out;
            2'd2:    s_wdata = DW'(s_pc_4);
            default: s_wdata = s_mem_out;
        endcase
    end

    // Head fields are zeroed when no entry is presented.
    assign wb_reg_waddr    = m_valid ? waddr_q[rd_ptr_q] : '0;
    assign wb_reg_wdata    = m_valid ? wdata_q[rd_ptr_q] : '0;
    assign wb_pc           = m_valid ? pc_q[rd_ptr_q] : '0;
    assign wb_instr        = m_valid ? instr_q[rd_ptr_q] : '0;
    assign wb_branch_taken = m_valid && bt_q[rd_ptr_q];
    assign wb_reg_wen      = ret && wen_q[rd_ptr_q]
                             && (waddr_q[rd_ptr_q] != '0);
    assign trap            = ret && (instr_q[rd_ptr_q] == EBREAK);

    // Walk oldest to youngest so the youngest match overwrites earlier ones.
    always_comb begin
        fwd_hit  = '0;
        fwd_data = '0;
        for (int i = 0; i < NUM_FWD; i++) begin
            for (int k = 0; k < DEPTH; k++) begin
                logic [AW-1:0] idx;
                logic [RW-1:0] ra;
                idx = rd_ptr_q + AW'(k);
                ra  = fwd_raddr[i*RW +: RW];
                if (vld_q[idx] && wen_q[idx] && ra != '0
                    && waddr_q[idx] == ra) begin
                    fwd_hit[i]            = 1'b1;
                    fwd_data[i*DW +: DW]  = wdata_q[idx];
                end
            end
        end
    end

    always_comb begin
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;
        retired_d = retired_q;
        vld_d     = vld_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        wdata_d   = wdata_q;
        waddr_d   = waddr_q;
        wen_d     = wen_q;
        bt_d      = bt_q;
        if (ret)
            retired_d = retired_q + CNT_WIDTH'(1);
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            vld_d    = '0;
        end else begin
            if (ret) begin
                vld_d[rd_ptr_q] = 1'b0;
                rd_ptr_d        = rd_ptr_q + AW'(1);
            end
            if (enq) begin
                vld_d[wr_ptr_q]   = 1'b1;
                pc_d[wr_ptr_q]    = s_pc;
                instr_d[wr_ptr_q] = s_instr;
                wdata_d[wr_ptr_q] = s_wdata;
                waddr_d[wr_ptr_q] = s_waddr;
                wen_d[wr_ptr_q]   = s_reg_wen;
                bt_d[wr_ptr_q]    = s_branch_taken;
                wr_ptr_d          = wr_ptr_q + AW'(1);
            end
            if (enq && !ret)
                count_d = count_q + (AW+1)'(1);
            else if (ret && !enq)
                count_d = count_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            retired_q <= '0;
            vld_q     <= '0;
        end else begin
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            retired_q <= retired_d;
            vld_q     <= vld_d;
        end
    end

    // Payload needs no reset: it is only observed through valid entries.
    always_ff @(posedge clk) begin
        pc_q    <= pc_d;
        instr_q <= instr_d;
        wdata_q <= wdata_d;
        waddr_q <= waddr_d;
        wen_q   <= wen_d;
        bt_q    <= bt_d;
    end

endmodule

// File: tb/tb_wbu_queue.sv
// Scoreboard bench for wbu_queue: random and directed traffic against a
// queue-based reference model, checked by an independent monitor.
module tb_wbu_queue;

    localparam int DEPTH = 4;
    localparam int NF    = 2;
    localparam logic [31:0] EBREAK = 32'h00100073;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [31:0] s_pc = '0, s_instr = '0, s_pc_4 = '0;
    logic        s_reg_wen = 1'b0;
    logic [1:0]  s_wb_sel = '0;
    logic [4:0]  s_waddr = '0;
    logic [31:0] s_alu_out = '0, s_mem_out = '0;
    logic        s_branch_taken = 1'b0;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic        wb_reg_wen;
    logic [4:0]  wb_reg_waddr;
    logic [31:0] wb_reg_wdata, wb_pc, wb_instr;
    logic        wb_branch_taken, trap;
    logic [9:0]  fwd_raddr = '0;
    logic [1:0]  fwd_hit;
    logic [63:0] fwd_data;
    logic [2:0]  count;
    logic [31:0] retired;

    wbu_queue dut (
        .clk(clk), .rst(rst), .flush(flush),
        .s_valid(s_valid), .s_ready(s_ready),
        .s_pc(s_pc), .s_instr(s_instr), .s_pc_4(s_pc_4),
        .s_reg_wen(s_reg_wen), .s_wb_sel(s_wb_sel), .s_waddr(s_waddr),
        .s_alu_out(s_alu_out), .s_mem_out(s_mem_out),
        .s_branch_taken(s_branch_taken),
        .m_valid(m_valid), .m_ready(m_ready),
        .wb_reg_wen(wb_reg_wen), .wb_reg_waddr(wb_reg_waddr),
        .wb_reg_wdata(wb_reg_wdata), .wb_pc(wb_pc), .wb_instr(wb_instr),
        .wb_branch_taken(wb_branch_taken), .trap(trap),
        .fwd_raddr(fwd_raddr), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
        .count(count), .retired(retired)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] wdata;
        logic        wen;
        logic [4:0]  waddr;
        logic        bt;
    } ent_t;

    ent_t        q[$];
    logic [31:0] ret_cnt = '0;
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    // Monitor: compares DUT outputs with the model 1 time unit after negedge.
    always @(negedge clk) begin
        #1;
        if (!rst) begin
            chk("rst_m_valid", m_valid, 0);
            chk("rst_wen", wb_reg_wen, 0);
            chk("rst_trap", trap, 0);
            chk("rst_fwd_hit", fwd_hit, 0);
            chk("rst_count", count, 0);
            chk("rst_retired", retired, 0);
        end else begin
            logic exp_mv, exp_ret;
            exp_mv = (q.size() != 0) && !flush;
            exp_ret = exp_mv && m_ready;
            chk("m_valid", m_valid, exp_mv);
            chk("count", count, q.size());
            chk("retired", retired, ret_cnt);
            chk("s_ready", s_ready,
                (q.size() < DEPTH) || (m_ready && exp_mv));
            for (int p = 0; p < NF; p++) begin
                logic [4:0]  a;
                logic        h;
                logic [31:0] d;
                a = fwd_raddr[p*5 +: 5];
                h = 1'b0;
                d = '0;
                if (a != 0)
                    for (int j = q.size() - 1; j >= 0; j--)
                        if (q[j].wen && q[j].waddr == a) begin
                            h = 1'b1;
                            d = q[j].wdata;
                            break;
                        end
                chk($sformatf("fwd_hit%0d", p), fwd_hit[p], h);
                chk($sformatf("fwd_data%0d", p), fwd_data[p*32 +: 32], d);
            end
            if (exp_mv) begin
                chk("wb_waddr", wb_reg_waddr, q[0].waddr);
                chk("wb_wdata", wb_reg_wdata, q[0].wdata);
                chk("wb_pc", wb_pc, q[0].pc);
                chk("wb_instr", wb_instr, q[0].instr);
                chk("wb_bt", wb_branch_taken, q[0].bt);
                chk("wb_reg_wen", wb_reg_wen,
                    exp_ret && q[0].wen && q[0].waddr != 0);
                chk("trap", trap, exp_ret && q[0].instr == EBREAK);
            end else begin
                chk("idle_wen", wb_reg_wen, 0);
                chk("idle_trap", trap, 0);
            end
            if (exp_ret) begin
                void'(q.pop_front());
                ret_cnt = ret_cnt + 1;
            end
        end
    end

    task automatic begin_cyc();
        @(negedge clk);
        s_valid        = 1'b0;
        m_ready        = 1'b1;
        flush          = 1'b0;
        s_pc           = $urandom & 32'hFFFF_FFFC;
        s_pc_4         = s_pc + 4;
        s_instr        = ($urandom_range(0, 7) == 0) ? EBREAK : $urandom;
        s_reg_wen      = 1'($urandom_range(0, 1));
        s_wb_sel       = 2'($urandom_range(0, 3));
        s_waddr        = 5'($urandom_range(0, 7));
        s_alu_out      = $urandom;
        s_mem_out      = $urandom;
        s_branch_taken = 1'($urandom_range(0, 1));
        fwd_raddr      = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
    endtask

    // Model update: records accepted entries after the monitor has run.
    task automatic end_cyc();
        ent_t e;
        #2;
        if (flush) begin
            q.delete();
        end else if (rst && s_valid && s_ready) begin
            e.pc    = s_pc;
            e.instr = s_instr;
            e.wen   = s_reg_wen;
            e.waddr = s_waddr;
            e.bt    = s_branch_taken;
            if (s_wb_sel == 2)
                e.wdata = s_pc_4;
            else if (s_wb_sel == 0)
                e.wdata = s_alu_out;
            else
                e.wdata = s_mem_out;
            q.push_back(e);
        end
    endtask

    task automatic put(input logic [31:0] pc, input logic [1:0] sel,
                       input logic [31:0] alu, input logic [4:0] wa,
                       input logic wen, input logic [31:0] ins);
        s_valid   = 1'b1;
        s_pc      = pc;
        s_pc_4    = pc + 4;
        s_wb_sel  = sel;
        s_alu_out = alu;
        s_waddr   = wa;
        s_reg_wen = wen;
        s_instr   = ins;
    endtask

    task automatic async_reset();
        #1;
        rst     = 1'b0;
        s_valid = 1'b0;
        flush   = 1'b0;
        #1;
        chk("async_rst_count", count, 0);
        chk("async_rst_m_valid", m_valid, 0);
        chk("async_rst_fwd_hit", fwd_hit, 0);
        q.delete();
        ret_cnt = '0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b1;

        // single entry, immediate retire
        begin_cyc(); put(32'h8000_0000, 0, 32'h1234, 5, 1, 32'h13); end_cyc();
        begin_cyc(); end_cyc();
        begin_cyc(); end_cyc();

        // fill under backpressure, then simultaneous retire+enqueue when full
        for (int i = 0; i < 5; i++) begin
            begin_cyc();
            m_ready = 1'b0;
            put(32'h100 + 4*i, 0, 32'hA0 + i, 5'(i + 1), 1, 32'h13);
            end_cyc();
        end
        begin_cyc(); put(32'h200, 0, 32'hB0, 9, 1, 32'h13); end_cyc();
        begin_cyc(); m_ready = 1'b0; end_cyc();
        repeat (5) begin begin_cyc(); end_cyc(); end

        // forwarding: youngest x7 wins, x0 never hits
        begin_cyc(); m_ready = 0; put(32'h300, 0, 32'h11, 7, 1, 32'h13); end_cyc();
        begin_cyc(); m_ready = 0; put(32'h304, 0, 32'h22, 7, 1, 32'h13); end_cyc();
        begin_cyc(); m_ready = 0; fwd_raddr = {5'd0, 5'd7}; end_cyc();
        repeat (3) begin begin_cyc(); end_cyc(); end

        // write to x0 is suppressed but still retires
        begin_cyc(); put(32'h400, 0, 32'h55, 0, 1, 32'h13); end_cyc();
        begin_cyc(); end_cyc();

        // ebreak held for three cycles, then retired
        begin_cyc(); m_ready = 0; put(32'h500, 0, 32'h0, 1, 0, EBREAK); end_cyc();
        repeat (3) begin begin_cyc(); m_ready = 0; end_cyc(); end
        repeat (2) begin begin_cyc(); end_cyc(); end

        // flush with three entries and a concurrent enqueue
        for (int i = 0; i < 3; i++) begin
            begin_cyc(); m_ready = 0;
            put(32'h600 + 4*i, 1, 32'h0, 5'(i + 2), 1, 32'h13);
            end_cyc();
        end
        begin_cyc(); m_ready = 0; flush = 1;
        put(32'h700, 0, 32'h77, 3, 1, 32'h13); end_cyc();
        repeat (2) begin begin_cyc(); end_cyc(); end

        // random traffic with occasional flushes and async resets
        for (int i = 0; i < 2000; i++) begin
            begin_cyc();
            s_valid = ($urandom_range(0, 3) != 0);
            m_ready = ($urandom_range(0, 2) != 0);
            flush   = ($urandom_range(0, 39) == 0);
            end_cyc();
            if (i == 700 || i == 1500)
                async_reset();
        end
        repeat (6) begin begin_cyc(); end_cyc(); end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
